neopixel_frame_loader: RTL and testbench
========================================

# neopixel_frame_loader

Upstream feeder for `NeoPixelStrandController`. Holds a host-writable shadow frame of per-pixel red/blue/green levels. On commit, the frame is snapshotted into an active buffer and replayed into the controller as a sequence of `load_color` transfers, followed by one `send_it`. It then waits for the strand transmission to finish before accepting the next frame.

## Interface
Parameters:
- `NUM_PIXELS`, default 5: pixels on the strand; legal range 1–8.
- `REFRESH_CYCLES`, default 1_000_000: auto-refresh period in clocks. Used only with `AUTO_REFRESH_EN`.

Ports:
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `wr_en`  in  1: write `wr_level` into the shadow entry at (`wr_pixel`, `wr_color`).
- `wr_pixel`  in  3: shadow pixel address.
- `wr_color`  in  2: colour select: 0 = red, 1 = blue, 2 = green, 3 = invalid.
- `wr_level`  in  8: colour level.
- `commit`  in  1: request transmission of the current shadow frame.
- `busy`  out  1: high in any state other than IDLE.
- `frame_done`  out  1: one-cycle pulse when a frame completes.
- `color_level`  out  8: to controller.
- `color_index`  out  2: to controller.
- `pixel_index`  out  3: to controller.
- `load_color`  out  1: to controller; valid strobe for the three fields above.
- `send_it`  out  1: to controller.
- `ready_to_load`  in  1: from controller.
- `ready_to_send`  in  1: from controller.

## Operation
- Storage: a shadow array and an active array, each `NUM_PIXELS` × 3 × 8 bits.
- Shadow writes:
  - A write happens on any edge with `wr_en` = 1, `wr_pixel` < `NUM_PIXELS` and `wr_color` ≠ 3.
  - Out-of-range writes are silently dropped.
  - Writes are accepted in every state.
- `commit` sets a sticky `pending` flag. A commit received while busy is held and serviced after the current frame. Multiple commits collapse into one.
- State machine:
  - IDLE: if `pending` is set, copy shadow to active, clear `pending`, go to LOAD.
  - LOAD: present active entries in order pixel 0..`NUM_PIXELS`-1, colour 0, 1, 2 within each pixel (3×`NUM_PIXELS` transfers).
    - `load_color` = 1 with the current fields.
    - A transfer completes on an edge where `load_color` and `ready_to_load` are both 1; the fields then advance.
    - While `ready_to_load` = 0, all fields are held stable.
    - After the last transfer, go to SEND.
  - SEND: `send_it` = 1, held until an edge where `ready_to_send` = 1. Then go to WAIT_START.
  - WAIT_START: wait for `ready_to_send` = 0 (transmission started), then go to WAIT_DONE.
  - WAIT_DONE: wait for `ready_to_load` = 1. Then pulse `frame_done` and go to IDLE.
- Shadow writes made during a frame affect only the next frame. The active buffer is never written outside the IDLE→LOAD edge.
- When `load_color` = 0, `color_level`, `color_index` and `pixel_index` drive 0.
- `color_index` = 3 is never emitted.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - `pending` = 0.
  - Both arrays zeroed.
  - Refresh counter 0.
- Reset asserted mid-frame aborts immediately. Outputs are 0 in the cycle after the reset edge.
- All outputs are registered.
- Frame start latency:
  - `commit` is sampled at edge k, so `pending` = 1 after k.
  - The IDLE→LOAD transition and snapshot occur at edge k+1. A `wr_en` on edge k is included in the snapshot.
  - `busy` and `load_color` (pixel 0, colour 0) are 1 from edge k+1.
- With `ready_to_load` held at 1, LOAD lasts exactly 3×`NUM_PIXELS` cycles (15 by default), and `send_it` rises on the edge after the last transfer.
- `frame_done` rises on the edge at which WAIT_DONE sees `ready_to_load` = 1. `busy` falls on the same edge.
- If `commit` and `frame_done` coincide, `pending` is set and the next frame starts one cycle later.

## Configuration
- Macro: `NEOPIXEL_AUTO_REFRESH_EN`.
- Defined:
  - A counter runs in IDLE only and clears on every IDLE→LOAD transition.
  - On reaching `REFRESH_CYCLES`-1 it sets `pending`, which retransmits the last snapshot plus any shadow edits.
- Undefined: no counter exists; frames start only from `commit`. `REFRESH_CYCLES` is unused.

## Test plan
- Write shadow p4/c0 = FF, p1/c1 = A0, p2/c2 = B3, then commit with `ready_to_load` = 1 → 15 consecutive `load_color` cycles carry exactly those levels at the matching indices, all others 00, followed by one `send_it` acceptance.
- Write with `wr_color` = 3 (value D4) and with `wr_pixel` = 6 → no change in the replayed frame; `color_index` is never 3.
- Drop `ready_to_load` for 4 cycles during transfer 7 → transfer 7 fields are held for 4 cycles with no skipped or duplicated entries; LOAD totals 19 cycles.
- Commit twice during WAIT_DONE, then write p0/c0 = 55 → exactly one extra frame, starting one cycle after `frame_done`, carrying 55.
- Assert `reset` during LOAD → all outputs 0 the next cycle; a later commit with no writes replays all zeros.
- With `NEOPIXEL_AUTO_REFRESH_EN` and `REFRESH_CYCLES` = 50 → after `frame_done`, the next frame starts 51 cycles later with no commit. Without the macro, there is no further activity.

Source files
------------

// File: rtl/neopixel_frame_loader_if.sv
// Loader-to-strand-controller link: colour transfer strobe with its fields, send request, controller readies.
// The loader is master; the strand controller is slave.
interface neopixel_frame_loader_if;
  logic [7:0] color_level;
  logic [1:0] color_index;
  logic [2:0] pixel_index;
  logic       load_color;
  logic       send_it;
  logic       ready_to_load;
  logic       ready_to_send;

  modport master (
    output color_level, color_index, pixel_index, load_color, send_it,
    input  ready_to_load, ready_to_send
  );

  modport slave (
    input  color_level, color_index, pixel_index, load_color, send_it,
    output ready_to_load, ready_to_send
  );
endinterface

// File: rtl/neopixel_frame_loader.sv
// Shadow/active frame buffer replaying a committed frame into the strand controller; all outputs registered.
// Optional NEOPIXEL_AUTO_REFRESH_EN retransmits the frame every REFRESH_CYCLES idle clocks.
module neopixel_frame_loader #(
  parameter int NUM_PIXELS     = 5,
  parameter int REFRESH_CYCLES = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_pixel,
  input  logic [1:0] wr_color,
  input  logic [7:0] wr_level,
  input  logic       commit,
  output logic       busy,
  output logic       frame_done,
  neopixel_frame_loader_if.master ctl
);

  if (NUM_PIXELS < 1 || NUM_PIXELS > 8 || REFRESH_CYCLES < 1) begin : g_param_check
    $error("neopixel_frame_loader: NUM_PIXELS must be 1..8 and REFRESH_CYCLES >= 1");
  end

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_START, WAIT_DONE} state_t;

  state_t     state;
  logic [7:0] shadow [NUM_PIXELS][3];
  logic [7:0] active [NUM_PIXELS][3];
  logic       pending;
  logic       start;
  logic       refresh_hit;
  logic       last_xfer;
  logic [2:0] next_pix;
  logic [1:0] next_col;

  always_comb begin
    start     = (state == IDLE) && pending;
    last_xfer = (ctl.pixel_index == 3'(NUM_PIXELS - 1)) && (ctl.color_index == 2'd2);
    next_pix  = ctl.pixel_index;
    next_col  = ctl.color_index + 2'd1;
    if (ctl.color_index == 2'd2) begin
      next_pix = ctl.pixel_index + 3'd1;
      next_col = 2'd0;
    end
  end

`ifdef NEOPIXEL_AUTO_REFRESH_EN
  localparam int CW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] refresh_cnt;

  // Counter saturates at its terminal value; the hit is masked once pending so it cannot re-arm on the start edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_cnt <= '0;
    end else if (start) begin
      refresh_cnt <= '0;
    end else if (state == IDLE && refresh_cnt != REFRESH_LAST) begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  assign refresh_hit = (state == IDLE) && !pending && (refresh_cnt == REFRESH_LAST);
`else
  assign refresh_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      pending         <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      ctl.load_color  <= 1'b0;
      ctl.send_it     <= 1'b0;
      ctl.color_level <= '0;
      ctl.color_index <= '0;
      ctl.pixel_index <= '0;
      for (int p = 0; p < NUM_PIXELS; p++) begin
        for (int c = 0; c < 3; c++) begin
          shadow[p][c] <= '0;
          active[p][c] <= '0;
        end
      end
    end else begin
      frame_done <= 1'b0;
      // A new request on the start edge survives the clear, so back-to-back frames are not lost.
      pending    <= (pending && !start) || commit || refresh_hit;

      if (wr_en && (int'(wr_pixel) < NUM_PIXELS) && (wr_color != 2'd3)) begin
        shadow[wr_pixel][wr_color] <= wr_level;
      end

      case (state)
        IDLE: begin
          if (pending) begin
            active          <= shadow;
            state           <= LOAD;
            busy            <= 1'b1;
            ctl.load_color  <= 1'b1;
            ctl.pixel_index <= 3'd0;
            ctl.color_index <= 2'd0;
            // The snapshot lands this edge, so the first level comes straight from the shadow.
            ctl.color_level <= shadow[0][0];
          end
        end

        LOAD: begin
          if (ctl.ready_to_load) begin
            if (last_xfer) begin
              ctl.load_color  <= 1'b0;
              ctl.pixel_index <= 3'd0;
              ctl.color_index <= 2'd0;
              ctl.color_level <= 8'd0;
              ctl.send_it     <= 1'b1;
              state           <= SEND;
            end else begin
              ctl.pixel_index <= next_pix;
              ctl.color_index <= next_col;
              ctl.color_level <= active[next_pix][next_col];
            end
          end
        end

        SEND: begin
          if (ctl.ready_to_send) begin
            ctl.send_it <= 1'b0;
            state       <= WAIT_START;
          end
        end

        WAIT_START: begin
          if (!ctl.ready_to_send) state <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (ctl.ready_to_load) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_frame_loader.sv
// Directed bench for neopixel_frame_loader: frame replay, dropped writes, load stall, commit collapse,
// mid-frame reset and (macro-dependent) auto refresh.
module tb_neopixel_frame_loader;
  logic       clock = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_pixel;
  logic [1:0] wr_color;
  logic [7:0] wr_level;
  logic       commit;
  logic       busy;
  logic       frame_done;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [7:0] exp_lv [15];
  logic       activity;

  always #5 clock = ~clock;

  neopixel_frame_loader_if ctl();

  neopixel_frame_loader #(.NUM_PIXELS(5), .REFRESH_CYCLES(50)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_pixel   (wr_pixel),
    .wr_color   (wr_color),
    .wr_level   (wr_level),
    .commit     (commit),
    .busy       (busy),
    .frame_done (frame_done),
    .ctl        (ctl)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [2:0] p, input logic [1:0] c, input logic [7:0] l);
    wr_en = 1'b1; wr_pixel = p; wr_color = c; wr_level = l;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic commit_pulse();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  // Entered on the first LOAD cycle; checks every presented transfer, holding for a stall if asked.
  task automatic check_load(input int stall_at, input int stall_len);
    logic [13:0] expf;
    for (int i = 0; i < 15; i++) begin
      expf = {1'b1, 3'(i / 3), 2'(i % 3), exp_lv[i]};
      if (i == stall_at) begin
        ctl.ready_to_load = 1'b0;
        repeat (stall_len) begin
          chk($sformatf("stall_hold_%0d", i),
              {ctl.load_color, ctl.pixel_index, ctl.color_index, ctl.color_level}, expf);
          tick();
        end
        ctl.ready_to_load = 1'b1;
      end
      chk($sformatf("xfer_%0d", i),
          {ctl.load_color, ctl.pixel_index, ctl.color_index, ctl.color_level}, expf);
      tick();
    end
  endtask

  // SEND held for one extra cycle, then accepted; leaves the DUT in WAIT_DONE with ready_to_load low.
  task automatic check_send();
    chk("send_up", {ctl.send_it, ctl.load_color, busy}, 3'b101);
    tick();
    chk("send_hold", ctl.send_it, 1'b1);
    ctl.ready_to_send = 1'b1;
    ctl.ready_to_load = 1'b0;
    tick();
    chk("send_ack", {ctl.send_it, busy}, 2'b01);
    ctl.ready_to_send = 1'b0;
    tick();
  endtask

  task automatic finish_frame();
    tick();
    chk("wait_done_hold", {frame_done, busy}, 2'b01);
    ctl.ready_to_load = 1'b1;
    tick();
    chk("frame_done", {frame_done, busy}, 2'b10);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_pixel = '0; wr_color = '0; wr_level = '0; commit = 1'b0;
    ctl.ready_to_load = 1'b1;
    ctl.ready_to_send = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_state", {busy, frame_done, ctl.load_color, ctl.send_it,
                        ctl.color_level, ctl.color_index, ctl.pixel_index}, 32'd0);

    // Frame 1: three live writes plus two that must be dropped.
    wr(3'd4, 2'd0, 8'hFF);
    wr(3'd1, 2'd1, 8'hA0);
    wr(3'd2, 2'd2, 8'hB3);
    wr(3'd0, 2'd3, 8'hD4);
    wr(3'd6, 2'd0, 8'hD4);
    for (int i = 0; i < 15; i++) exp_lv[i] = 8'h00;
    exp_lv[12] = 8'hFF;
    exp_lv[4]  = 8'hA0;
    exp_lv[8]  = 8'hB3;
    commit_pulse();
    chk("commit_latency", {busy, ctl.load_color}, 2'b00);
    tick();
    check_load(-1, 0);
    check_send();
    finish_frame();

    // Frame 2: same data, ready_to_load dropped for 4 cycles on transfer 7.
    tick();
    chk("done_pulse_end", {frame_done, busy}, 2'b00);
    commit_pulse();
    tick();
    check_load(7, 4);
    check_send();

    // Two commits and a write while in WAIT_DONE: one extra frame carrying 55.
    commit_pulse();
    tick();
    commit_pulse();
    wr(3'd0, 2'd0, 8'h55);
    finish_frame();
    exp_lv[0] = 8'h55;
    tick();
    chk("collapsed_start", busy, 1'b1);
    check_load(-1, 0);
    check_send();
    finish_frame();
    repeat (5) begin
      tick();
      chk("no_extra_frame", {busy, ctl.load_color, frame_done}, 3'b000);
    end

    // Reset mid-LOAD, then a commit replays an all-zero frame.
    commit_pulse();
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("reset_mid_load", {busy, frame_done, ctl.load_color, ctl.send_it,
                           ctl.color_level, ctl.color_index, ctl.pixel_index}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) exp_lv[i] = 8'h00;
    commit_pulse();
    tick();
    check_load(-1, 0);
    check_send();
    finish_frame();

`ifdef NEOPIXEL_AUTO_REFRESH_EN
    repeat (50) tick();
    chk("refresh_not_yet", {busy, ctl.load_color}, 2'b00);
    tick();
    chk("refresh_start", {busy, ctl.load_color, ctl.pixel_index, ctl.color_index, ctl.color_level},
        {1'b1, 1'b1, 3'd0, 2'd0, 8'h00});
`else
    activity = 1'b0;
    repeat (60) begin
      tick();
      activity = activity | busy | ctl.load_color | ctl.send_it | frame_done;
    end
    chk("no_refresh", activity, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
